// File: rtl/wb_arb_pkg.sv
// Shared definitions for the CPU/DMA Wishbone arbiter and the DMA sequencer
// that sizes its bursts against the same limits.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int BURST_MAX_DEF = 64;
  localparam int TIMEOUT_DEF   = 255;

endpackage

// File: rtl/wb_arb_timeout.sv
// Wrapping event counter: counts enabled cycles and pulses hit on the event
// that brings the count to LIMIT, returning to zero on that same event.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] cnt;

  assign hit = en && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || hit) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/wb_dma_arbiter.sv
// Round-robin Wishbone arbiter: Caravel CPU (m0) and DMA sequencer (m1) share
// the FIR/matmul BRAM slave; DMA bursts are capped and dead beats time out.
module wb_dma_arbiter
  import wb_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  arb_state_e state, state_d;
  logic       last_m1;
  logic       to_fire;
  logic       stb_raw;
  logic       ack_eff;
  logic       grant_chg;
  logic       beat_hit;
  logic       to_hit;

  assign grant_chg = (state_d != state);
  assign s_stb_o   = stb_raw & ~to_fire;
  assign ack_eff   = s_ack_i & s_stb_o;

  // A burst-cap handover passes through IDLE with last owner = m1, which
  // yields the one-cycle bus gap and then hands the tie to m0.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state   <= ST_IDLE;
      last_m1 <= 1'b1;
      to_fire <= 1'b0;
    end else begin
      state <= state_d;
      if (state == ST_GNT0 && state_d != ST_GNT0) begin
        last_m1 <= 1'b0;
      end else if (state == ST_GNT1 && state_d != ST_GNT1) begin
        last_m1 <= 1'b1;
      end
      to_fire <= to_hit && !grant_chg;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_m1 ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end else if (beat_hit && m0_cyc_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o   = GNT_NONE;
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (state)
      ST_GNT0: begin
        gnt_o   = GNT_M0;
        s_cyc_o = m0_cyc_i;
        stb_raw = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      ST_GNT1: begin
        gnt_o   = GNT_M1;
        s_cyc_o = m1_cyc_i;
        stb_raw = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_ack_o = ack_eff & gnt_o[0];
  assign m1_ack_o = ack_eff & gnt_o[1];
  assign m0_err_o = to_fire & gnt_o[0];
  assign m1_err_o = to_fire & gnt_o[1];
  assign m0_dat_o = gnt_o[0] ? s_dat_i : '0;
  assign m1_dat_o = gnt_o[1] ? s_dat_i : '0;

  // Acks coinciding with the last count never reach hit since en excludes them.
  wb_arb_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .clr   (!s_stb_o || s_ack_i || grant_chg),
    .en    (s_stb_o && !s_ack_i),
    .hit   (to_hit)
  );

  wb_arb_timeout #(.LIMIT(BURST_MAX)) u_beats (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .clr   ((state != ST_GNT1) || grant_chg),
    .en    ((state == ST_GNT1) && ack_eff),
    .hit   (beat_hit)
  );

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Bench for wb_dma_arbiter with BURST_MAX=4, TIMEOUT=8 and a one-wait-state slave.
module tb_wb_dma_arbiter;

  localparam int BM = 4;
  localparam int TO = 8;
  localparam logic [31:0] RD_PAT = 32'h5A5A_F00F;

  logic        clk;
  logic        rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   m0_acks = 0;
  int   m1_acks = 0;
  logic slv_auto = 1'b1;
  logic ack_force = 1'b0;
  logic abort_xfer = 1'b0;
  logic ack_reg;

  wb_dma_arbiter #(.BURST_MAX(BM), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),      .wb_rst_ni(rst_n),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
    .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
    .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o  (s_we_o),
    .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o (s_dat_o),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .gnt_o   (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: acks one cycle after it sees a strobe, read data derived from address.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_reg <= 1'b0;
    else        ack_reg <= slv_auto && s_cyc_o && s_stb_o && !ack_reg;
  end
  assign s_ack_i = ack_reg | ack_force;
  assign s_dat_i = s_ack_i ? (s_adr_o ^ RD_PAT) : 32'h0;

  // Scoreboard: every master ack pops the oldest expected beat of that master.
  always @(negedge clk) begin
    exp_t e;
    if (m0_ack_o) begin
      m0_acks++;
      total_cnt++;
      if (q0.size() == 0) begin
        $display("FAIL m0_ack_unexpected adr=%h required=no ack", s_adr_o);
      end else begin
        e = q0.pop_front();
        if (s_adr_o !== e.adr || s_we_o !== e.we || (e.we ? s_dat_o : m0_dat_o) !== e.dat
            || m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0)
          $display("FAIL m0_beat adr=%h dat=%h we=%b required adr=%h dat=%h we=%b",
                   s_adr_o, e.we ? s_dat_o : m0_dat_o, s_we_o, e.adr, e.dat, e.we);
        else pass_cnt++;
      end
    end
    if (m1_ack_o) begin
      m1_acks++;
      total_cnt++;
      if (q1.size() == 0) begin
        $display("FAIL m1_ack_unexpected adr=%h required=no ack", s_adr_o);
      end else begin
        e = q1.pop_front();
        if (s_adr_o !== e.adr || s_we_o !== e.we || (e.we ? s_dat_o : m1_dat_o) !== e.dat
            || m0_dat_o !== 32'h0)
          $display("FAIL m1_beat adr=%h dat=%h we=%b required adr=%h dat=%h we=%b",
                   s_adr_o, e.we ? s_dat_o : m1_dat_o, s_we_o, e.adr, e.dat, e.we);
        else pass_cnt++;
      end
    end
  end

  task automatic drive(input int id, input logic cyc, input logic [31:0] adr, input logic we);
    if (id == 0) begin
      m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we & cyc;
      m0_sel_i = cyc ? 4'hF : 4'h0;
      m0_adr_i = cyc ? adr : 32'h0;
      m0_dat_i = cyc ? ~adr : 32'h0;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we & cyc;
      m1_sel_i = cyc ? 4'hF : 4'h0;
      m1_adr_i = cyc ? adr : 32'h0;
      m1_dat_i = cyc ? ~adr : 32'h0;
    end
  endtask

  task automatic present(input int id, input logic [31:0] adr, input logic we);
    exp_t e;
    e.adr = adr;
    e.we  = we;
    e.dat = we ? ~adr : (adr ^ RD_PAT);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    drive(id, 1'b1, adr, we);
  endtask

  task automatic m_xfer(input int id, input logic [31:0] base, input int n, input logic we);
    int beat;
    int cyc_cnt;
    logic got;
    beat = 0;
    cyc_cnt = 0;
    @(posedge clk); #1;
    present(id, base, we);
    while (beat < n && cyc_cnt < 400 && !abort_xfer) begin
      @(negedge clk);
      got = (id == 0) ? m0_ack_o : m1_ack_o;
      @(posedge clk); #1;
      cyc_cnt++;
      if (got) begin
        beat++;
        if (beat < n) present(id, base + 32'(4 * beat), we);
      end
    end
    drive(id, 1'b0, 32'h0, 1'b0);
    if (!abort_xfer) begin
      total_cnt++;
      if (beat != n) $display("FAIL xfer_m%0d_done beats=%0d required=%0d", id, beat, n);
      else pass_cnt++;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0);
    #3;
    drive(0, 1'b1, 32'h3800_0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (gnt_o !== 2'b00) $display("FAIL reset_gnt gnt=%b required=00", gnt_o); else pass_cnt++;
    total_cnt++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) $display("FAIL reset_s_ctl cyc/stb/we=%b required=000", {s_cyc_o, s_stb_o, s_we_o});
    else pass_cnt++;
    total_cnt++;
    if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0) $display("FAIL reset_s_bus adr=%h dat=%h required=0", s_adr_o, s_dat_o);
    else pass_cnt++;
    total_cnt++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) $display("FAIL reset_ack_err got=%b required=0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    else pass_cnt++;
    drive(0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_only();
    exp_t e;
    @(posedge clk); #1;
    e.adr = 32'h3800_0130; e.dat = 32'hDEAD_BEEF; e.we = 1'b1;
    q0.push_back(e);
    drive(0, 1'b1, 32'h3800_0130, 1'b1);
    m0_dat_i = 32'hDEAD_BEEF;
    @(negedge clk);
    total_cnt++;
    if (gnt_o !== 2'b00) $display("FAIL cpu_grant_latency gnt=%b required=00", gnt_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h3800_0130 || m0_ack_o !== 1'b0)
      $display("FAIL cpu_granted gnt=%b cyc=%b adr=%h ack=%b required 01 1 38000130 0", gnt_o, s_cyc_o, s_adr_o, m0_ack_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (m0_ack_o !== 1'b1) $display("FAIL cpu_ack ack=%b required=1", m0_ack_o); else pass_cnt++;
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (s_cyc_o !== 1'b0) $display("FAIL cpu_release_cyc cyc=%b required=0", s_cyc_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (gnt_o !== 2'b00) $display("FAIL cpu_idle gnt=%b required=00", gnt_o); else pass_cnt++;
  endtask

  task automatic test_tie();
    logic [1:0] h[5];
    logic [1:0] ex[5];
    ex = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    apply_reset();
    fork
      m_xfer(0, 32'h3800_0100, 1, 1'b0);
      m_xfer(1, 32'h3800_0800, 2, 1'b0);
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          h[i] = gnt_o;
        end
      end
    join
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (h[i] !== ex[i]) $display("FAIL tie_gnt_seq cycle=%0d gnt=%b required=%b", i, h[i], ex[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_burst_cap();
    m0_acks = 0;
    m1_acks = 0;
    fork
      m_xfer(1, 32'h3800_1000, 10, 1'b0);
      begin
        for (int i = 0; i < 200 && m1_acks < 2; i++) begin @(negedge clk); #2; end
        m_xfer(0, 32'h3800_0200, 1, 1'b1);
      end
      begin
        for (int i = 0; i < 200 && m1_acks < BM; i++) begin @(negedge clk); #2; end
        @(negedge clk);
        total_cnt++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0)
          $display("FAIL cap_gap gnt=%b cyc=%b stb=%b m1_ack=%b required 00 0 0 0", gnt_o, s_cyc_o, s_stb_o, m1_ack_o);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1) $display("FAIL cap_handover gnt=%b cyc=%b required 01 1", gnt_o, s_cyc_o);
        else pass_cnt++;
        for (int i = 0; i < 50 && m0_acks < 1; i++) begin @(negedge clk); #2; end
        total_cnt++;
        if (m1_acks !== BM) $display("FAIL cap_m1_stalled m1_acks=%0d required=%0d", m1_acks, BM);
        else pass_cnt++;
      end
    join
    total_cnt++;
    if (m1_acks !== 10 || m0_acks !== 1) $display("FAIL cap_totals m1_acks=%0d m0_acks=%0d required 10 1", m1_acks, m0_acks);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    slv_auto = 1'b0;
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h3800_2000, 1'b0);
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= TO) begin
        total_cnt++;
        if (m1_err_o !== 1'b0 || gnt_o !== 2'b10 || s_stb_o !== 1'b1)
          $display("FAIL to_wait k=%0d err=%b gnt=%b stb=%b required 0 10 1", k, m1_err_o, gnt_o, s_stb_o);
        else pass_cnt++;
      end else if (k == TO + 1) begin
        total_cnt++;
        if (m1_err_o !== 1'b1 || s_stb_o !== 1'b0) $display("FAIL to_fire err=%b stb=%b required 1 0", m1_err_o, s_stb_o);
        else pass_cnt++;
        total_cnt++;
        if (m1_ack_o !== 1'b0 || m0_err_o !== 1'b0 || gnt_o !== 2'b10)
          $display("FAIL to_late_ack m1_ack=%b m0_err=%b gnt=%b required 0 0 10", m1_ack_o, m0_err_o, gnt_o);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (m1_err_o !== 1'b0 || s_stb_o !== 1'b1) $display("FAIL to_after err=%b stb=%b required 0 1", m1_err_o, s_stb_o);
        else pass_cnt++;
      end
      @(posedge clk); #1;
      if (k == TO) ack_force = 1'b1;
      if (k == TO + 1) ack_force = 1'b0;
    end
    drive(1, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    slv_auto = 1'b1;
  endtask

  task automatic test_ack_timeout_collision();
    slv_auto = 1'b0;
    @(posedge clk); #1;
    present(1, 32'h3800_2040, 1'b0);
    @(posedge clk); #1;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) begin
        total_cnt++;
        if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0) $display("FAIL coll_ack ack=%b err=%b required 1 0", m1_ack_o, m1_err_o);
        else pass_cnt++;
      end else if (k == TO + 1) begin
        total_cnt++;
        if (m1_err_o !== 1'b0 || m0_err_o !== 1'b0) $display("FAIL coll_no_err m1_err=%b m0_err=%b required 0 0", m1_err_o, m0_err_o);
        else pass_cnt++;
      end
      @(posedge clk); #1;
      if (k == TO - 1) ack_force = 1'b1;
      if (k == TO) begin
        ack_force = 1'b0;
        drive(1, 1'b0, 32'h0, 1'b0);
      end
    end
    slv_auto = 1'b1;
  endtask

  task automatic test_reset_mid();
    m1_acks = 0;
    abort_xfer = 1'b0;
    fork
      m_xfer(1, 32'h3800_3000, 10, 1'b0);
      begin
        for (int i = 0; i < 100 && m1_acks < 3; i++) begin @(negedge clk); #2; end
        #1;
        abort_xfer = 1'b1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0)
          $display("FAIL rst_mid_async gnt=%b cyc=%b stb=%b ack=%b required 00 0 0 0", gnt_o, s_cyc_o, s_stb_o, m1_ack_o);
        else pass_cnt++;
        repeat (3) @(posedge clk);
      end
    join
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    abort_xfer = 1'b0;
    fork
      m_xfer(0, 32'h3800_0400, 1, 1'b0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if (gnt_o !== 2'b00) $display("FAIL rst_fresh_idle gnt=%b required=00", gnt_o); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (gnt_o !== 2'b01 || s_cyc_o !== 1'b1) $display("FAIL rst_fresh_grant gnt=%b cyc=%b required 01 1", gnt_o, s_cyc_o);
        else pass_cnt++;
      end
    join
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_tie();
    test_burst_cap();
    test_timeout();
    test_ack_timeout_collision();
    test_reset_mid();
    repeat (2) @(posedge clk);
    total_cnt++;
    if (q0.size() != 0 || q1.size() != 0) $display("FAIL scoreboard_drain q0=%0d q1=%0d required 0 0", q0.size(), q1.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
